// File: rtl/r2r_dac_wavegen.sv
// r2r_dac_wavegen: waveform generator driving an R2R ladder DAC.
// A reloadable divider produces ticks; each tick advances the waveform phase.
//
// Parameters:
//   WIDTH  - DAC code width (4..12)
//   DIV_W  - divider width (1..WIDTH)
// Ports:
//   clk          - clock, rising edge
//   n_rst        - synchronous active-low reset
//   mode         - 00 EXT, 01 SAW, 10 TRI, 11 SQUARE
//   load_divider - load data[DIV_W-1:0] into divider reload and counter
//   data         - external DAC code (EXT) / divider value (load)
//   r2r_out      - registered DAC code
//   cnt_zero     - divider counter is zero
//   wrap         - one-cycle pulse at each waveform period boundary
// Configuration:
//   R2R_WAVE_TRIANGLE_EN - when defined, mode 10 is a triangle; otherwise
//                          mode 10 behaves as the sawtooth.
module r2r_dac_wavegen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [1:0]       mode,
    input  logic             load_divider,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] r2r_out,
    output logic             cnt_zero,
    output logic             wrap
);

    localparam logic [1:0] MODE_EXT    = 2'b00;
    localparam logic [1:0] MODE_SQUARE = 2'b11;
`ifdef R2R_WAVE_TRIANGLE_EN
    localparam logic [1:0] MODE_TRI    = 2'b10;
`endif
    localparam logic [WIDTH-1:0] PHASE_MAX = '1;

    logic [DIV_W-1:0] div_reg, div_next;
    logic [DIV_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] phase, phase_next;
    logic [WIDTH-1:0] out_next;
    logic [1:0]       mode_q;
    logic             wrap_next;
    logic             tick;
`ifdef R2R_WAVE_TRIANGLE_EN
    logic             dir_up, dir_next;
`endif

    // Output derived only from the registered counter.
    assign cnt_zero = (cnt == '0);

    // Divider: a load suppresses the tick for that cycle.
    always_comb begin
        div_next = div_reg;
        cnt_next = cnt;
        tick     = 1'b0;
        if (load_divider) begin
            div_next = data[DIV_W-1:0];
            cnt_next = data[DIV_W-1:0];
        end else if (cnt == '0) begin
            tick     = 1'b1;
            cnt_next = div_reg;
        end else begin
            cnt_next = cnt - DIV_W'(1);
        end
    end

    // Waveform phase and output code.
    always_comb begin
        phase_next = phase;
        out_next   = r2r_out;
        wrap_next  = 1'b0;
`ifdef R2R_WAVE_TRIANGLE_EN
        dir_next   = dir_up;
`endif
        if (mode != mode_q) begin
            // A mode switch restarts the waveform from zero.
            phase_next = '0;
            out_next   = '0;
`ifdef R2R_WAVE_TRIANGLE_EN
            dir_next   = 1'b1;
`endif
        end else begin
            case (mode)
                MODE_EXT: begin
                    out_next = data;
                end
                MODE_SQUARE: begin
                    if (tick) begin
                        phase_next = (phase == '0) ? PHASE_MAX : '0;
                        wrap_next  = (phase == '0);
                    end
                    out_next = phase_next;
                end
`ifdef R2R_WAVE_TRIANGLE_EN
                MODE_TRI: begin
                    // Direction flips on arrival at an endpoint so neither end is held.
                    if (tick) begin
                        if (dir_up) begin
                            phase_next = phase + WIDTH'(1);
                            if (phase_next == PHASE_MAX) dir_next = 1'b0;
                        end else begin
                            phase_next = phase - WIDTH'(1);
                            if (phase_next == '0) begin
                                dir_next  = 1'b1;
                                wrap_next = 1'b1;
                            end
                        end
                    end
                    out_next = phase_next;
                end
`endif
                default: begin
                    if (tick) begin
                        phase_next = phase + WIDTH'(1);
                        wrap_next  = (phase == PHASE_MAX);
                    end
                    out_next = phase_next;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            div_reg <= '0;
            cnt     <= '0;
            phase   <= '0;
            mode_q  <= 2'b00;
            r2r_out <= '0;
            wrap    <= 1'b0;
`ifdef R2R_WAVE_TRIANGLE_EN
            dir_up  <= 1'b1;
`endif
        end else begin
            div_reg <= div_next;
            cnt     <= cnt_next;
            phase   <= phase_next;
            mode_q  <= mode;
            r2r_out <= out_next;
            wrap    <= wrap_next;
`ifdef R2R_WAVE_TRIANGLE_EN
            dir_up  <= dir_next;
`endif
        end
    end

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Self-checking bench for r2r_dac_wavegen (WIDTH=8, DIV_W=8).
// The reference model tracks the number of ticks since the waveform restarted
// and computes the expected code directly from that count.
module tb_r2r_dac_wavegen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV_W = 8;
    localparam int MAXV = 255;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [1:0]       mode;
    logic             load_divider;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] r2r_out;
    logic             cnt_zero;
    logic             wrap;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_div, m_cnt, m_k, m_mode_q, m_out;
    bit m_wrap;

    r2r_dac_wavegen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .n_rst(n_rst), .mode(mode), .load_divider(load_divider),
        .data(data), .r2r_out(r2r_out), .cnt_zero(cnt_zero), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit tri_en();
`ifdef R2R_WAVE_TRIANGLE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Expected code after k ticks in a given mode.
    function automatic int wave_val(input int md, input int k);
        if (md == 3) return (k % 2 == 1) ? MAXV : 0;
        if (md == 2 && tri_en()) begin
            int m;
            m = k % (2 * MAXV);
            return (m <= MAXV) ? m : 2 * MAXV - m;
        end
        return k % (MAXV + 1);
    endfunction

    // Whether the k-th tick is a period boundary.
    function automatic bit wave_wrap(input int md, input int k);
        if (md == 3) return (k % 2 == 1);
        if (md == 2 && tri_en()) return (k % (2 * MAXV) == 0);
        return (k % (MAXV + 1) == 0);
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        bit tk;
        if (!n_rst) begin
            m_div = 0; m_cnt = 0; m_k = 0; m_mode_q = 0; m_out = 0; m_wrap = 0;
            return;
        end
        tk = !load_divider && (m_cnt == 0);
        if (load_divider) begin
            m_div = int'(data[DIV_W-1:0]);
            m_cnt = m_div;
        end else if (m_cnt == 0) begin
            m_cnt = m_div;
        end else begin
            m_cnt = m_cnt - 1;
        end
        m_wrap = 0;
        if (int'(mode) != m_mode_q) begin
            m_mode_q = int'(mode);
            m_k = 0;
            m_out = 0;
        end else if (mode == 2'b00) begin
            m_out = int'(data);
        end else if (tk) begin
            m_k++;
            m_out = wave_val(int'(mode), m_k);
            m_wrap = wave_wrap(int'(mode), m_k);
        end
    endtask

    // One clock with checks sampled 1 time unit after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_eq({tag, ".r2r_out"}, int'(r2r_out), m_out);
        check_eq({tag, ".wrap"}, int'(wrap), int'(m_wrap));
        check_eq({tag, ".cnt_zero"}, int'(cnt_zero), int'(m_cnt == 0));
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic load_div(input int v);
        load_divider = 1'b1;
        data = WIDTH'(v);
        cycle("load");
        load_divider = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; mode = 2'b00; load_divider = 1'b0; data = '0;
        m_div = 0; m_cnt = 0; m_k = 0; m_mode_q = 0; m_out = 0; m_wrap = 0;
        run("reset", 2);
        check_eq("reset.const_out", int'(r2r_out), 0);
        check_eq("reset.const_cz", int'(cnt_zero), 1);

        // Sawtooth at full rate, including the 255 -> 0 wrap.
        n_rst = 1'b1; mode = 2'b01;
        cycle("saw_start");
        check_eq("saw.first_zero", int'(r2r_out), 0);
        run("saw", 600);

        // Divide by 4.
        load_div(3);
        run("saw_div4", 40);

        // Triangle (or sawtooth alias) at full rate over more than two periods.
        load_div(0);
        mode = 2'b10;
        run("tri", 1100);

        // External code, then switch to square.
        mode = 2'b00;
        run("ext_sw", 1);
        data = 8'hA5;
        cycle("ext");
        check_eq("ext.a5", int'(r2r_out), 8'hA5);
        for (int i = 0; i < 10; i++) begin
            data = WIDTH'($urandom);
            cycle("ext_rand");
        end
        mode = 2'b11;
        cycle("sq_sw");
        check_eq("sq.first_zero", int'(r2r_out), 0);
        run("square", 20);

        // Reset mid-ramp at phase 0x40 with divider 5.
        mode = 2'b01;
        load_div(5);
        for (int i = 0; i < 2000 && !(r2r_out == 8'h40 && m_cnt == 0); i++) cycle("ramp");
        check_eq("ramp.reached_40", int'(r2r_out), 8'h40);
        n_rst = 1'b0;
        cycle("mid_rst");
        n_rst = 1'b1;
        run("after_rst", 10);

        // Randomised mix of modes, loads, data and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
            load_divider = ($urandom_range(0, 149) == 0);
            data = WIDTH'($urandom);
            if (load_divider) data = WIDTH'($urandom_range(0, 3));
            n_rst = ($urandom_range(0, 399) != 0);
            cycle("rand");
        end
        n_rst = 1'b1; load_divider = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/r2r_dac_wavegen.md
R2R_DAC_WAVEGEN -- requirements
Module: r2r_dac_wavegen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the R2R DAC code width in bits (range 4..12).
REQ-002 SHALL have parameter DIV_W, default 8, meaning the clock-divider width in bits (range 1..WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port n_rst, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port mode, input, 2, waveform select: 00 EXT, 01 SAW, 10 TRI, 11 SQUARE.
REQ-006 SHALL have port load_divider, input, 1, which loads data[DIV_W-1:0] into the divider reload register.
REQ-007 SHALL have port data, input, WIDTH, carrying the external DAC code in EXT mode and the divider value when load_divider=1.
REQ-008 SHALL have port r2r_out, output, WIDTH, the registered code driven to the R2R level shifters.
REQ-009 SHALL have port cnt_zero, output, 1, high while the divider counter equals 0.
REQ-010 SHALL have port wrap, output, 1, a one-cycle pulse at each waveform period boundary.

Function
REQ-011 The divider SHALL hold div_reg and cnt: load_divider=1 sets both to data[DIV_W-1:0], with no tick that cycle; otherwise cnt=0 produces a tick and reloads cnt from div_reg; otherwise cnt decrements.
REQ-012 The tick period SHALL be div_reg+1 clocks; div_reg=0 ticks every cycle with cnt_zero held high.
REQ-013 cnt_zero SHALL be derived from the registered cnt only (no combinational path from inputs).
REQ-014 EXT: r2r_out SHALL equal data sampled at the previous edge (1-cycle latency, not gated by tick); phase frozen; wrap=0.
REQ-015 SAW: on each tick phase SHALL increment mod 2^WIDTH; r2r_out=phase; wrap pulses on the tick where phase goes from all-ones to 0.
REQ-016 TRI: phase SHALL step up by 1 per tick to all-ones, then down to 0, then up (sequence 0,1,..,MAX,MAX-1,..,0,1); the endpoints are never held for two ticks; wrap pulses on the tick where phase reaches 0.
REQ-017 SQUARE: r2r_out SHALL toggle between 0 and all-ones on each tick; wrap pulses on the 0-to-all-ones transition.
REQ-018 r2r_out in SAW, TRI and SQUARE SHALL update on the clock edge following the tick, i.e. registered from phase.
REQ-019 When mode differs from mode_q (registered mode), phase SHALL clear to 0, direction SHALL set to up and r2r_out SHALL clear to 0 on that edge; wrap=0 that cycle.
REQ-020 A mode change and load_divider in the same cycle SHALL both take effect.
REQ-021 wrap SHALL be registered and high for exactly one clock per event.

Reset
REQ-022 With n_rst=0 at a rising edge: div_reg=0, cnt=0, phase=0, direction=up, mode_q=00, r2r_out=0, wrap=0; cnt_zero therefore reads 1.
REQ-023 Reset SHALL override load_divider, mode change and tick, including mid-ramp; the first tick after release occurs on the first enabled cycle.

Configuration
REQ-024 Macro R2R_WAVE_TRIANGLE_EN defined: TRI mode SHALL be implemented as in REQ-016.
REQ-025 Macro R2R_WAVE_TRIANGLE_EN undefined: no direction flop SHALL exist and mode 10 SHALL behave identically to SAW (mode 01).

Verification
REQ-026 WIDTH=8, reset, mode=01, no load -> r2r_out 1,2,3,.. on consecutive cycles; wrap pulses when r2r_out goes 255 to 0 (at 256 cycles).
REQ-027 load_divider=1 with data=3, mode=01 -> cnt_zero high 1 cycle in 4; r2r_out increments once every 4 cycles.
REQ-028 mode=10, div=0 -> r2r_out 0..255..0 over 510 cycles with no repeated 255 or 0; wrap high at each 0; with the macro undefined the output instead matches the sawtooth.
REQ-029 mode=00, data=0xA5 -> r2r_out=0xA5 one cycle later; then switching to mode=11 -> r2r_out=0 on the next edge, then toggles 0xFF/0x00.
REQ-030 n_rst=0 for 1 cycle mid-ramp (phase=0x40), div=5 -> all outputs reset, cnt_zero=1, div_reg=0, ramp restarts from 1.
